// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Constants and FSM state encoding shared by the UART TX/RX.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int BIT_NUMBER = 8;
  localparam int FRAME_LEN  = BIT_NUMBER + 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_GAP   = 3'd4
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with a combinational head read, occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : FIFO-buffered UART transmitter, high start bit, low stop bit.
//               Optional UART_TX_IDLE_GAP_EN inserts IDLE_GAP low cycles
//               after every stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int BIT_NUMBER = uart_pkg::BIT_NUMBER,
  parameter int FIFO_DEPTH = 4
`ifdef UART_TX_IDLE_GAP_EN
  , parameter int IDLE_GAP = 2
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BIT_NUMBER-1:0]         data_in,
  input  logic                          valid,
  output logic                          ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_done
);

  import uart_pkg::*;

  localparam int IDX_W = (BIT_NUMBER > 1) ? $clog2(BIT_NUMBER) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BIT_NUMBER - 1);

  tx_state_e             state;
  logic [BIT_NUMBER-1:0] shift_reg;
  logic [BIT_NUMBER-1:0] fifo_rdata;
  logic [IDX_W-1:0]      bit_idx;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;

`ifdef UART_TX_IDLE_GAP_EN
  // IDLE_GAP must be at least 1.
  localparam int GAP_W = $clog2(IDLE_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_GAP - 1);
  logic [GAP_W-1:0] gap_cnt;
`endif

  assign ready     = !fifo_full;
  assign fifo_push = valid && ready;
  assign busy      = (state != ST_IDLE) || !fifo_empty;

  always_comb begin
    fifo_pop = 1'b0;
    case (state)
      ST_IDLE: fifo_pop = !fifo_empty;
`ifdef UART_TX_IDLE_GAP_EN
      ST_GAP:  fifo_pop = !fifo_empty && (gap_cnt == GAP_LAST);
`else
      ST_STOP: fifo_pop = !fifo_empty;
`endif
      default: fifo_pop = 1'b0;
    endcase
  end

  sync_fifo #(
    .WIDTH (BIT_NUMBER),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (data_in),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // txd is the registered image of the state being left on each edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      txd       <= 1'b0;
      tx_done   <= 1'b0;
      bit_idx   <= '0;
      shift_reg <= '0;
`ifdef UART_TX_IDLE_GAP_EN
      gap_cnt   <= '0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          txd <= 1'b0;
          if (fifo_pop) begin
            shift_reg <= fifo_rdata;
            bit_idx   <= '0;
            state     <= ST_START;
          end
        end
        ST_START: begin
          txd   <= 1'b1;
          state <= ST_DATA;
        end
        ST_DATA: begin
          txd     <= shift_reg[bit_idx];
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == LAST_IDX) state <= ST_STOP;
        end
        ST_STOP: begin
          txd     <= 1'b0;
          tx_done <= 1'b1;
`ifdef UART_TX_IDLE_GAP_EN
          gap_cnt <= '0;
          state   <= ST_GAP;
`else
          if (fifo_pop) begin
            shift_reg <= fifo_rdata;
            bit_idx   <= '0;
            state     <= ST_START;
          end else begin
            state <= ST_IDLE;
          end
`endif
        end
`ifdef UART_TX_IDLE_GAP_EN
        ST_GAP: begin
          txd     <= 1'b0;
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GAP_LAST) begin
            if (fifo_pop) begin
              shift_reg <= fifo_rdata;
              bit_idx   <= '0;
              state     <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
`endif
        default: begin
          txd   <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Scoreboard bench for uart_tx_fifo with a frame-decoding monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int BN    = 8;
  localparam int DEPTH = 4;
`ifdef UART_TX_IDLE_GAP_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 0;
`endif
  localparam int PERIOD = BN + 2 + GAP;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       ready;
  logic       txd;
  logic       busy;
  logic [2:0] fifo_count;
  logic       tx_done;

  uart_tx_fifo #(
    .BIT_NUMBER (BN),
    .FIFO_DEPTH (DEPTH)
`ifdef UART_TX_IDLE_GAP_EN
    , .IDLE_GAP (GAP)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .valid      (valid),
    .ready      (ready),
    .txd        (txd),
    .busy       (busy),
    .fifo_count (fifo_count),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  logic [7:0] sb[$];
  int         starts[$];
  int         cyc = 0;
  int         frames = 0;
  int         mon_state = 0;
  int         mon_bits = 0;
  logic [7:0] mon_byte = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Receiver model: high start bit, 8 data bits LSB first, low stop bit.
  always @(negedge clk) begin
    if (rst) begin
      mon_state = 0;
      mon_bits  = 0;
    end else begin
      check_eq("count_le_depth", 32'(int'(fifo_count) <= DEPTH), 1);
      case (mon_state)
        0: begin
          check_eq("tx_done_idle", 32'(tx_done), 0);
          if (txd) begin
            mon_state = 1;
            mon_bits  = 0;
            starts.push_back(cyc);
          end
        end
        1: begin
          check_eq("tx_done_data", 32'(tx_done), 0);
          mon_byte = {txd, mon_byte[7:1]};
          mon_bits++;
          if (mon_bits == BN) mon_state = 2;
        end
        default: begin
          check_eq("stop_bit", 32'(txd), 0);
          check_eq("tx_done_stop", 32'(tx_done), 1);
          check_eq("sb_nonempty", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) check_eq("rx_byte", 32'(mon_byte), 32'(sb.pop_front()));
          frames++;
          mon_state = 0;
        end
      endcase
    end
  end

  function automatic logic exp_txd(input logic [7:0] b, input int e);
    int off;
    off = e - 2;
    if (off == 0) return 1'b1;
    if (off >= 1 && off <= 8) return b[off-1];
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds valid until the byte is taken; leaves valid asserted on return.
  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    data_in = b;
    valid   = 1'b1;
    while (!ready && t < 200) begin
      tick();
      t++;
    end
    check_eq("send_ready", 32'(ready), 1);
    sb.push_back(b);
    tick();
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || busy) && t < 500) begin
      tick();
      t++;
    end
    check_eq("drain_sb_empty", sb.size(), 0);
    repeat (2) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int f0;

    repeat (3) tick();
    check_eq("rst_txd", 32'(txd), 0);
    check_eq("rst_tx_done", 32'(tx_done), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_ready", 32'(ready), 1);
    check_eq("rst_count", 32'(fifo_count), 0);
    rst = 1'b0;
    tick();

    // Single byte, cycle-exact waveform.
    data_in = 8'hA5;
    valid   = 1'b1;
    sb.push_back(8'hA5);
    tick();
    valid = 1'b0;
    check_eq("single_count_e0", 32'(fifo_count), 1);
    check_eq("single_busy_e0", 32'(busy), 1);
    for (int e = 1; e <= 13; e++) begin
      tick();
      check_eq($sformatf("single_txd_e%0d", e), 32'(txd), 32'(exp_txd(8'hA5, e)));
      check_eq($sformatf("single_done_e%0d", e), 32'(tx_done), 32'(e == 11));
    end
    drain();

    // Back-to-back frames.
    starts.delete();
    f0 = frames;
    send(8'h01);
    send(8'h80);
    send(8'hFF);
    valid = 1'b0;
    drain();
    check_eq("b2b_frames", frames - f0, 3);
    check_eq("b2b_starts", starts.size(), 3);
    if (starts.size() >= 3) begin
      check_eq("b2b_period_1", starts[1] - starts[0], PERIOD);
      check_eq("b2b_period_2", starts[2] - starts[1], PERIOD);
    end

    // FIFO full while a frame is in flight.
    send(8'h11);
    valid = 1'b0;
    tick();
    tick();
    f0 = frames;
    send(8'h22);
    send(8'h33);
    send(8'h44);
    send(8'h66);
    check_eq("full_ready", 32'(ready), 0);
    check_eq("full_count", 32'(fifo_count), 4);
    send(8'h77);
    valid = 1'b0;
    check_eq("full_fifth_after_pop", frames - f0, 1);
    check_eq("full_count_after", 32'(fifo_count), 4);
    drain();

    // Push on the STOP-cycle pop edge with two bytes queued.
    send(8'hC1);
    send(8'hC2);
    send(8'hC3);
    valid = 1'b0;
    repeat (8) tick();
    check_eq("simul_count_pre", 32'(fifo_count), 2);
    data_in = 8'hC4;
    valid   = 1'b1;
    tick();
    valid = 1'b0;
    sb.push_back(8'hC4);
`ifndef UART_TX_IDLE_GAP_EN
    check_eq("simul_count", 32'(fifo_count), 2);
    check_eq("simul_tx_done", 32'(tx_done), 1);
    tick();
    check_eq("simul_no_gap", 32'(txd), 1);
`endif
    drain();

    // Reset during data bit 3 of 8'h3C with two bytes queued.
    send(8'h3C);
    send(8'hAA);
    send(8'hBB);
    valid = 1'b0;
    repeat (4) tick();
    check_eq("mid_bit3", 32'(txd), 1);
    check_eq("mid_count", 32'(fifo_count), 2);
    rst = 1'b1;
    tick();
    sb.delete();
    check_eq("mid_rst_txd", 32'(txd), 0);
    check_eq("mid_rst_count", 32'(fifo_count), 0);
    check_eq("mid_rst_busy", 32'(busy), 0);
    check_eq("mid_rst_ready", 32'(ready), 1);
    rst = 1'b0;
    tick();
    f0 = frames;
    send(8'h55);
    valid = 1'b0;
    drain();
    check_eq("post_rst_frames", frames - f0, 1);

`ifdef UART_TX_IDLE_GAP_EN
    starts.delete();
    send(8'hC3);
    send(8'h5A);
    valid = 1'b0;
    for (int t = 0; t < 60 && sb.size() != 0; t++) begin
      check_eq("gap_busy", 32'(busy), 1);
      tick();
    end
    check_eq("gap_busy_end", 32'(busy), 1);
    drain();
    check_eq("gap_starts", starts.size(), 2);
    if (starts.size() >= 2) check_eq("gap_period", starts[1] - starts[0], 12);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Simplified UART transmitter that sits directly upstream of the UART receiver stage.
- Accepts bytes over a valid/ready handshake and buffers them in a small synchronous FIFO.
- Serializes each byte at one bit per clock in the framing the receiver expects:
  - idle line low
  - one-cycle high start bit
  - 8 data bits, LSB first
  - one-cycle low stop bit
- Back-to-back frames are 10 cycles each, with no idle gap.

Parameters:
- BIT_NUMBER, 8, data bits per frame.
- FIFO_DEPTH, 4, FIFO entries; must be a power of two, >= 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  BIT_NUMBER  byte to transmit.
- valid  input  1  data_in is valid this cycle.
- ready  output  1  FIFO can accept a byte; equals !full.
- txd  output  1  serial line to the receiver's rxd; registered.
- busy  output  1  high when the FSM is not IDLE, or the FIFO is non-empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.
- tx_done  output  1  one-cycle pulse during the STOP cycle of each frame.

Behaviour:
- Reset (clk and rst exactly as named above; reset synchronous, active-high):
  - FIFO pointers and count go to 0.
  - state goes to IDLE; txd=0, tx_done=0, busy=0, ready=1.
  - Reset mid-frame aborts the frame immediately, and txd is 0 on the next cycle.
  - Any queued bytes are discarded.
- Handshake:
  - A push occurs on a rising edge with valid && ready; ready is combinational from full.
  - valid while full is ignored; the byte is not stored and there is no error flag.
- FIFO:
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Pop only when not empty.
- FSM states are IDLE, START, DATA and STOP. txd is updated on the same edge as state:
  - IDLE: txd=0. If the FIFO is non-empty: pop into shift_reg, bit_idx<=0, go to START.
  - START: txd=1 for exactly one cycle, then go to DATA.
  - DATA: txd=shift_reg[bit_idx]; bit_idx increments each cycle. After bit_idx==BIT_NUMBER-1, go to STOP. Lasts exactly 8 cycles.
  - STOP: txd=0 and tx_done=1 for one cycle. If the FIFO is non-empty, pop and go to START; otherwise go to IDLE.
- Latency:
  - A push into an empty FIFO with the FSM in IDLE at edge k puts the FIFO non-empty from k+1.
  - The pop happens at edge k+1, so txd is 1 (START) from edge k+2.
- Throughput: one frame per 10 cycles when the FIFO stays non-empty.
- Widths:
  - bit_idx is $clog2(BIT_NUMBER) bits and is never compared against 8 in a width that overflows.
  - fifo_count is wide enough to hold FIFO_DEPTH.
- The stop bit is always 0. This guarantees a 0->1 edge at the next start bit even when the last data bit was 1.

Optional Feature:
- Macro: UART_TX_IDLE_GAP_EN
- With the macro defined:
  - Adds parameter IDLE_GAP (default 2).
  - After each STOP, the FSM spends IDLE_GAP additional cycles in a GAP state with txd=0 before it may pop again.
  - Frame period becomes 10+IDLE_GAP cycles.
  - busy stays high during GAP.
- Without the macro: there is no GAP state, and STOP may go directly to START.

Decomposition:
- Shared package uart_pkg holds:
  - BIT_NUMBER
  - FRAME_LEN=BIT_NUMBER+2
  - the state encoding typedef/localparams (IDLE=0, START=1, DATA=2, STOP=3, GAP=4)
- The receiver shares the same package constants.
- Sub-module sync_fifo holds the storage, pointers, count, full and empty. It is parameterized by WIDTH and DEPTH, and its reset is synchronous.
- uart_tx_fifo holds the FSM, the shift register and the handshake glue.

Test Plan:
- Single byte: push 8'hA5 at edge 0 with the FSM idle → txd from edge 2 is 1,1,0,1,0,0,1,0,1,0, then idle 0. tx_done pulses once, on the STOP cycle (edge 11).
- Back-to-back: push 8'h01, 8'h80, 8'hFF on consecutive cycles → three contiguous 10-cycle frames with no idle cycles. The start bit follows a stop bit of 0 each time. A connected receiver reports data 01, 80, FF.
- FIFO full: with FIFO_DEPTH=4 and the FSM busy, push 5 bytes with valid held high → ready=0 after the 4th is stored. The 5th is accepted only after the first pop, and fifo_count never exceeds 4.
- Simultaneous push/pop: push exactly on the STOP-cycle pop edge with fifo_count=2 → fifo_count stays 2 and the next frame starts with no gap.
- Reset mid-frame: assert rst during data bit 3 of 8'h3C with 2 bytes queued → next cycle txd=0, fifo_count=0, busy=0, ready=1. After reset, a fresh push of 8'h55 is transmitted correctly.
- With UART_TX_IDLE_GAP_EN and IDLE_GAP=2: send two queued bytes → exactly 2 low cycles between the first STOP and the second START, a 12-cycle period, and busy high throughout.
